// File: rtl/dpll_pkg.sv
// ---------------------------------------------------------------------------
// dpll_pkg : shared widths, defaults, state encoding and divider helper
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package dpll_pkg;

   localparam int unsigned PERIOD_W = 8;
   localparam int unsigned WDOG_W   = 10;

   localparam int unsigned DEF_DIV_MULT       = 5;
   localparam int unsigned DEF_NUM_MEAS       = 4;
   localparam int unsigned DEF_PERIOD_TOL     = 2;
   localparam int unsigned DEF_LOCK_CONFIRM   = 8;
   localparam int unsigned DEF_UNLOCK_CONFIRM = 4;
   localparam int unsigned DEF_ACQ_TIMEOUT    = 64;
   localparam int unsigned DEF_EDGE_TIMEOUT   = 1023;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MEASURE  = 3'd1,
      ACQUIRE  = 3'd2,
      TRACK    = 3'd3,
      HOLDOVER = 3'd4
   } dpllState_t;

   // Truncating divide by a constant; a zero result would stall the divider
   function automatic logic [PERIOD_W-1:0] calcDividerMax(
      input logic [PERIOD_W-1:0] period,
      input int unsigned         divMult
   );
      logic [PERIOD_W-1:0] quotient;
      quotient = period / PERIOD_W'(divMult);
      return (quotient == '0) ? PERIOD_W'(1) : quotient;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dpll_period_qualifier.sv
// ---------------------------------------------------------------------------
// dpll_period_qualifier : min/max spread check over a window of input edges
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dpll_period_qualifier
   import dpll_pkg::*;
#(
   parameter int unsigned NUM_MEAS   = DEF_NUM_MEAS,
   parameter int unsigned PERIOD_TOL = DEF_PERIOD_TOL
) (
   input  logic                MainClock,
   input  logic                ResetN,
   input  logic                clear,
   input  logic                sampleEdge,
   input  logic [PERIOD_W-1:0] periodCount,
   output logic                qualified,
   output logic [PERIOD_W-1:0] qualPeriod
);

   logic [3:0]          edgeCnt;
   logic [PERIOD_W-1:0] minQ;
   logic [PERIOD_W-1:0] maxQ;
   logic [PERIOD_W-1:0] minNext;
   logic [PERIOD_W-1:0] maxNext;
   logic                lastEdge;

   always_comb begin
      minNext    = (edgeCnt == '0 || periodCount < minQ) ? periodCount : minQ;
      maxNext    = (edgeCnt == '0 || periodCount > maxQ) ? periodCount : maxQ;
      lastEdge   = (edgeCnt == 4'(NUM_MEAS - 1));
      qualified  = sampleEdge && (periodCount != '0) && lastEdge &&
                   ((maxNext - minNext) <= PERIOD_W'(PERIOD_TOL));
      qualPeriod = periodCount;
   end

   // A zero period or a completed window (pass or fail) starts a fresh window
   always_ff @(posedge MainClock or negedge ResetN) begin
      if (!ResetN) begin
         edgeCnt <= '0;
         minQ    <= '0;
         maxQ    <= '0;
      end else if (clear) begin
         edgeCnt <= '0;
         minQ    <= '0;
         maxQ    <= '0;
      end else if (sampleEdge) begin
         if (periodCount == '0 || lastEdge) begin
            edgeCnt <= '0;
         end else begin
            edgeCnt <= edgeCnt + 4'd1;
            minQ    <= minNext;
            maxQ    <= maxNext;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dpll_lock_controller.sv
// ---------------------------------------------------------------------------
// dpll_lock_controller : DPLL measure/acquire/track sequencer with watchdog
// Optional LockLossCount output when DPLL_LOCK_STATS_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dpll_lock_controller
   import dpll_pkg::*;
#(
   parameter int unsigned DIV_MULT       = DEF_DIV_MULT,
   parameter int unsigned NUM_MEAS       = DEF_NUM_MEAS,
   parameter int unsigned PERIOD_TOL     = DEF_PERIOD_TOL,
   parameter int unsigned LOCK_CONFIRM   = DEF_LOCK_CONFIRM,
   parameter int unsigned UNLOCK_CONFIRM = DEF_UNLOCK_CONFIRM,
   parameter int unsigned ACQ_TIMEOUT    = DEF_ACQ_TIMEOUT,
   parameter int unsigned EDGE_TIMEOUT   = DEF_EDGE_TIMEOUT
) (
   input  logic                MainClock,
   input  logic                ResetN,
   input  logic                Enable,
   input  logic                InputSignalEdge,
   input  logic                Lock,
   input  logic [PERIOD_W-1:0] PeriodCount,
   output logic [PERIOD_W-1:0] DividerMax,
   output logic                LoopEnable,
   output logic                FastMode,
   output logic                Locked,
   output logic                LossOfLock,
   output logic [2:0]          State
`ifdef DPLL_LOCK_STATS_EN
   ,
   output logic [7:0]          LockLossCount
`endif
);

   dpllState_t          state;
   dpllState_t          stateNext;
   logic [7:0]          confirmCnt;
   logic [7:0]          missCnt;
   logic [7:0]          acqEdgeCnt;
   logic [WDOG_W-1:0]   wdog;
   logic [7:0]          confirmNext;
   logic [7:0]          missNext;
   logic [7:0]          acqEdgeNext;
   logic [WDOG_W-1:0]   wdogNext;
   logic                wdogActive;
   logic                lossEvent;
   logic                loadDiv;
   logic                qualClear;
   logic                qualified;
   logic [PERIOD_W-1:0] qualPeriod;

   assign qualClear = (state != MEASURE) || (stateNext != MEASURE);

   dpll_period_qualifier #(
      .NUM_MEAS   (NUM_MEAS),
      .PERIOD_TOL (PERIOD_TOL)
   ) uQualifier (
      .MainClock   (MainClock),
      .ResetN      (ResetN),
      .clear       (qualClear),
      .sampleEdge  (InputSignalEdge),
      .periodCount (PeriodCount),
      .qualified   (qualified),
      .qualPeriod  (qualPeriod)
   );

   always_comb begin
      stateNext   = state;
      lossEvent   = 1'b0;
      loadDiv     = 1'b0;
      wdogActive  = (state == MEASURE) || (state == ACQUIRE) || (state == TRACK);
      wdogNext    = InputSignalEdge ? '0 :
                    ((wdog == '1) ? wdog : wdog + WDOG_W'(1));
      confirmNext = Lock ? confirmCnt + 8'd1 : 8'd0;
      missNext    = Lock ? 8'd0 : missCnt + 8'd1;
      acqEdgeNext = acqEdgeCnt + 8'd1;

      case (state)
         IDLE:     stateNext = MEASURE;
         MEASURE: begin
            if (qualified) begin
               stateNext = ACQUIRE;
               loadDiv   = 1'b1;
            end
         end
         ACQUIRE: begin
            if (InputSignalEdge) begin
               if (confirmNext == 8'(LOCK_CONFIRM))
                  stateNext = TRACK;
               else if (acqEdgeNext == 8'(ACQ_TIMEOUT))
                  stateNext = MEASURE;
            end
         end
         TRACK: begin
            if (InputSignalEdge && missNext == 8'(UNLOCK_CONFIRM)) begin
               stateNext = ACQUIRE;
               lossEvent = 1'b1;
            end
         end
         HOLDOVER: begin
            if (InputSignalEdge)
               stateNext = MEASURE;
         end
         default:  stateNext = IDLE;
      endcase

      if (wdogActive && wdogNext == WDOG_W'(EDGE_TIMEOUT)) begin
         stateNext = HOLDOVER;
         lossEvent = 1'b0;
         loadDiv   = 1'b0;
      end

      if (!Enable) begin
         stateNext = IDLE;
         lossEvent = 1'b0;
         loadDiv   = 1'b0;
      end
   end

   // Mode outputs are decoded from the next state so they move with State
   always_ff @(posedge MainClock or negedge ResetN) begin
      if (!ResetN) begin
         state      <= IDLE;
         confirmCnt <= '0;
         missCnt    <= '0;
         acqEdgeCnt <= '0;
         wdog       <= '0;
         DividerMax <= '0;
         LoopEnable <= 1'b0;
         FastMode   <= 1'b1;
         Locked     <= 1'b0;
         LossOfLock <= 1'b0;
      end else begin
         state      <= stateNext;
         LoopEnable <= (stateNext == ACQUIRE) || (stateNext == TRACK);
         FastMode   <= (stateNext != TRACK);
         Locked     <= (stateNext == TRACK);
         LossOfLock <= lossEvent;
         if (loadDiv)
            DividerMax <= calcDividerMax(qualPeriod, DIV_MULT);

         if (stateNext != state) begin
            confirmCnt <= '0;
            missCnt    <= '0;
            acqEdgeCnt <= '0;
            wdog       <= '0;
         end else begin
            if (wdogActive)
               wdog <= wdogNext;
            if (InputSignalEdge && state == ACQUIRE) begin
               confirmCnt <= confirmNext;
               acqEdgeCnt <= acqEdgeNext;
            end
            if (InputSignalEdge && state == TRACK)
               missCnt <= missNext;
         end
      end
   end

   assign State = state;

`ifdef DPLL_LOCK_STATS_EN
   always_ff @(posedge MainClock or negedge ResetN) begin
      if (!ResetN)
         LockLossCount <= '0;
      else if ((lossEvent || (stateNext == HOLDOVER && state != HOLDOVER)) &&
               LockLossCount != 8'hFF)
         LockLossCount <= LockLossCount + 8'd1;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dpll_lock_controller.sv
// ---------------------------------------------------------------------------
// tb_dpll_lock_controller : directed self-checking bench for the lock sequencer
// Rev 1.0  : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dpll_lock_controller;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_MEASURE  = 3'd1;
   localparam logic [2:0] S_ACQUIRE  = 3'd2;
   localparam logic [2:0] S_TRACK    = 3'd3;
   localparam logic [2:0] S_HOLDOVER = 3'd4;

   logic       MainClock = 1'b0;
   logic       ResetN;
   logic       Enable;
   logic       InputSignalEdge;
   logic       Lock;
   logic [7:0] PeriodCount;
   logic [7:0] DividerMax;
   logic       LoopEnable;
   logic       FastMode;
   logic       Locked;
   logic       LossOfLock;
   logic [2:0] State;
`ifdef DPLL_LOCK_STATS_EN
   logic [7:0] LockLossCount;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 MainClock = ~MainClock;

   dpll_lock_controller dut (
      .MainClock       (MainClock),
      .ResetN          (ResetN),
      .Enable          (Enable),
      .InputSignalEdge (InputSignalEdge),
      .Lock            (Lock),
      .PeriodCount     (PeriodCount),
      .DividerMax      (DividerMax),
      .LoopEnable      (LoopEnable),
      .FastMode        (FastMode),
      .Locked          (Locked),
      .LossOfLock      (LossOfLock),
      .State           (State)
`ifdef DPLL_LOCK_STATS_EN
      ,
      .LockLossCount   (LockLossCount)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge MainClock);
         #1;
      end
   endtask

   // gap idle cycles, then a one-cycle edge pulse; returns just after its posedge
   task automatic edges(input logic [7:0] p, input logic lk, input int n, input int gap);
      repeat (n) begin
         tick(gap);
         InputSignalEdge = 1'b1;
         PeriodCount     = p;
         Lock            = lk;
         tick(1);
         InputSignalEdge = 1'b0;
      end
   endtask

   initial begin
      ResetN          = 1'b0;
      Enable          = 1'b0;
      InputSignalEdge = 1'b0;
      Lock            = 1'b0;
      PeriodCount     = 8'd0;
      tick(3);
      check("rst_state", 32'(State), 32'(S_IDLE));
      check("rst_divmax", 32'(DividerMax), 32'd0);
      check("rst_loopen", 32'(LoopEnable), 32'd0);
      check("rst_fast", 32'(FastMode), 32'd1);
      check("rst_locked", 32'(Locked), 32'd0);
      check("rst_lol", 32'(LossOfLock), 32'd0);
`ifdef DPLL_LOCK_STATS_EN
      check("rst_stats", 32'(LockLossCount), 32'd0);
`endif

      ResetN = 1'b1;
      Enable = 1'b1;
      tick(1);
      check("idle_to_measure", 32'(State), 32'(S_MEASURE));

      // period 40 for four edges -> divider 8
      edges(8'd40, 1'b0, 3, 39);
      check("meas_3_edges", 32'(State), 32'(S_MEASURE));
      edges(8'd40, 1'b0, 1, 39);
      check("meas_done_state", 32'(State), 32'(S_ACQUIRE));
      check("meas_done_div", 32'(DividerMax), 32'd8);
      check("acq_loopen", 32'(LoopEnable), 32'd1);
      check("acq_fast", 32'(FastMode), 32'd1);

      // seven locks then a miss keeps acquiring
      edges(8'd40, 1'b1, 7, 39);
      edges(8'd40, 1'b0, 1, 39);
      check("acq_7_then_miss", 32'(State), 32'(S_ACQUIRE));
      edges(8'd40, 1'b1, 7, 39);
      check("acq_7_locks", 32'(State), 32'(S_ACQUIRE));
      edges(8'd40, 1'b1, 1, 39);
      check("track_state", 32'(State), 32'(S_TRACK));
      check("track_locked", 32'(Locked), 32'd1);
      check("track_fast", 32'(FastMode), 32'd0);
      check("track_loopen", 32'(LoopEnable), 32'd1);

      // four misses -> loss of lock
      edges(8'd40, 1'b0, 3, 39);
      check("track_3_miss", 32'(State), 32'(S_TRACK));
      edges(8'd40, 1'b0, 1, 39);
      check("lol_state", 32'(State), 32'(S_ACQUIRE));
      check("lol_pulse", 32'(LossOfLock), 32'd1);
      check("lol_locked", 32'(Locked), 32'd0);
      check("lol_fast", 32'(FastMode), 32'd1);
      tick(1);
      check("lol_pulse_end", 32'(LossOfLock), 32'd0);
`ifdef DPLL_LOCK_STATS_EN
      check("stats_after_lol", 32'(LockLossCount), 32'd1);
`endif

      // relock, then starve the input for the watchdog
      edges(8'd40, 1'b1, 8, 39);
      check("relock_state", 32'(State), 32'(S_TRACK));
      tick(1022);
      check("wdog_1022", 32'(State), 32'(S_TRACK));
      tick(1);
      check("wdog_1023", 32'(State), 32'(S_HOLDOVER));
      check("hold_div", 32'(DividerMax), 32'd8);
      check("hold_loopen", 32'(LoopEnable), 32'd0);
      check("hold_locked", 32'(Locked), 32'd0);
`ifdef DPLL_LOCK_STATS_EN
      check("stats_after_hold", 32'(LockLossCount), 32'd2);
`endif
      edges(8'd60, 1'b0, 1, 5);
      check("hold_to_measure", 32'(State), 32'(S_MEASURE));

      // spread 4 rejected, spread 2 accepted; last period 61 -> 12
      edges(8'd60, 1'b0, 1, 39);
      edges(8'd64, 1'b0, 1, 39);
      edges(8'd60, 1'b0, 2, 39);
      check("spread4_reject", 32'(State), 32'(S_MEASURE));
      check("spread4_div", 32'(DividerMax), 32'd8);
      edges(8'd60, 1'b0, 1, 39);
      edges(8'd62, 1'b0, 1, 39);
      edges(8'd60, 1'b0, 1, 39);
      edges(8'd61, 1'b0, 1, 39);
      check("spread2_state", 32'(State), 32'(S_ACQUIRE));
      check("spread2_div", 32'(DividerMax), 32'd12);

      // Enable low in ACQUIRE
      Enable = 1'b0;
      tick(1);
      check("dis_state", 32'(State), 32'(S_IDLE));
      check("dis_div_held", 32'(DividerMax), 32'd12);
      check("dis_loopen", 32'(LoopEnable), 32'd0);
      Enable = 1'b1;
      tick(1);
      check("reen_state", 32'(State), 32'(S_MEASURE));

      // zero period restarts the window; 3/5 clamps to 1
      edges(8'd3, 1'b0, 2, 39);
      edges(8'd0, 1'b0, 1, 39);
      edges(8'd3, 1'b0, 3, 39);
      check("zero_restart", 32'(State), 32'(S_MEASURE));
      edges(8'd3, 1'b0, 1, 39);
      check("clamp_state", 32'(State), 32'(S_ACQUIRE));
      check("clamp_div", 32'(DividerMax), 32'd1);

      // acquisition timeout after 64 edges without lock
      edges(8'd3, 1'b0, 63, 1);
      check("acq_63_edges", 32'(State), 32'(S_ACQUIRE));
      edges(8'd3, 1'b0, 1, 1);
      check("acq_timeout", 32'(State), 32'(S_MEASURE));
      check("acq_timeout_loopen", 32'(LoopEnable), 32'd0);

      // back to TRACK, then asynchronous reset
      edges(8'd40, 1'b0, 4, 39);
      edges(8'd40, 1'b1, 8, 39);
      check("pre_reset_track", 32'(State), 32'(S_TRACK));
      ResetN = 1'b0;
      #2;
      check("async_state", 32'(State), 32'(S_IDLE));
      check("async_div", 32'(DividerMax), 32'd0);
      check("async_locked", 32'(Locked), 32'd0);
      check("async_fast", 32'(FastMode), 32'd1);
      check("async_loopen", 32'(LoopEnable), 32'd0);
      tick(2);
      ResetN = 1'b1;
      tick(1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

`default_nettype wire
